period_monitor: RTL

PERIOD_MONITOR -- requirements
Module: period_monitor

---
 rtl/period_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/period_monitor.sv
// Multi-channel rising-edge period monitor: measures the clk-cycle period of each input,
// flags out-of-tolerance/saturated periods and serves results round-robin over a valid/ready port.
module period_monitor #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TOL   = 2,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  sig,
    input  logic [CNT_W-1:0] exp_period,
    input  logic             clr,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CH_W-1:0]  meas_ch,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_err,
    output logic [N_CH-1:0]  timeout,
    output logic [N_CH-1:0]  drop
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);

    state_t           state  [N_CH];
    logic [CNT_W-1:0] count  [N_CH];
    logic [CNT_W-1:0] pend_p [N_CH];
    logic [N_CH-1:0]  prev;
    logic [N_CH-1:0]  pend_v;
    logic [N_CH-1:0]  pend_e;
    logic [CH_W-1:0]  rr_ptr;

    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  res_v;
    logic [N_CH-1:0]  res_e;
    logic [N_CH-1:0]  acc;
    logic [N_CH-1:0]  cand;
    logic [CNT_W:0]   hi_lim;
    logic             xfer;
    logic [CH_W-1:0]  start;
    logic [CH_W-1:0]  sel;
    logic             found;

    always_comb begin
        hi_lim = {1'b0, exp_period} + TOL_X;
        xfer   = meas_valid & meas_ready;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rise[i]  = sig[i] & ~prev[i];
            res_v[i] = en & rise[i] & (state[i] == RUN);
            res_e[i] = (count[i] == CNT_MAX)
                     | ({1'b0, count[i]} > hi_lim)
                     | (({1'b0, count[i]} + TOL_X) < {1'b0, exp_period});
        end
        acc = '0;
        if (xfer) acc[meas_ch] = 1'b1;
        // Search starts just after the channel being accepted this cycle, else at the stored pointer.
        start = xfer ? CH_W'((32'(meas_ch) + 32'd1) % N_CH) : rr_ptr;
        cand  = pend_v & ~acc;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!found && cand[(32'(start) + k) % N_CH]) begin
                found = 1'b1;
                sel   = CH_W'((32'(start) + k) % N_CH);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev        <= '0;
            pend_v      <= '0;
            pend_e      <= '0;
            timeout     <= '0;
            drop        <= '0;
            rr_ptr      <= '0;
            meas_valid  <= 1'b0;
            meas_ch     <= '0;
            meas_period <= '0;
            meas_err    <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state[i]  <= IDLE;
                count[i]  <= '0;
                pend_p[i] <= '0;
            end
        end else begin
            prev <= sig;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!en) begin
                    state[i] <= IDLE;
                    count[i] <= '0;
                end else if (rise[i]) begin
                    state[i] <= RUN;
                    count[i] <= CNT_ONE;
                end else if (state[i] == RUN && count[i] != CNT_MAX) begin
                    count[i] <= count[i] + CNT_ONE;
                end

                if (res_v[i]) begin
                    pend_v[i] <= 1'b1;
                    pend_p[i] <= count[i];
                    pend_e[i] <= res_e[i];
                end else if (acc[i]) begin
                    pend_v[i] <= 1'b0;
                end

                if (res_v[i] && pend_v[i] && !acc[i]) drop[i] <= 1'b1;
                else if (clr)                          drop[i] <= 1'b0;

                if (en && state[i] == RUN && !rise[i] && count[i] == CNT_MAX - CNT_ONE)
                    timeout[i] <= 1'b1;
                else if (clr)
                    timeout[i] <= 1'b0;
            end

            if (xfer) rr_ptr <= start;

            // Output registers shadow the pending slot; a same-cycle new result is forwarded
            // so the presented value never lags an overwrite of that channel.
            if (meas_valid && !meas_ready) begin
                if (res_v[meas_ch]) begin
                    meas_period <= count[meas_ch];
                    meas_err    <= res_e[meas_ch];
                end
            end else if (found) begin
                meas_valid  <= 1'b1;
                meas_ch     <= sel;
                meas_period <= res_v[sel] ? count[sel] : pend_p[sel];
                meas_err    <= res_v[sel] ? res_e[sel] : pend_e[sel];
            end else begin
                meas_valid  <= 1'b0;
            end
        end
    end

endmodule
